imem_load_arbiter: RTL and testbench

Sole owner of the single-port, 32-word instruction memory. Sequences boot-time program loading from a loader port, then shares the memory between the pipeline fetch stage (reads) and the loader (runtime patch writes). Sits between the IF stage, the instruction memory array and the program loader. Holds the pipeline in stall until the image is loaded.

---
 rtl/imem_load_arbiter_pkg.sv | 8 +
 rtl/imem_rr_arb2.sv | 24 ++
 rtl/imem_load_arbiter.sv | 91 +++++++++
 tb/tb_imem_load_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/imem_load_arbiter_pkg.sv
// imem_load_arbiter_pkg: shared encodings and sizes for the instruction-memory load arbiter
package imem_load_arbiter_pkg;
   typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_e;
   typedef enum logic {LOADER = 1'b0, FETCH = 1'b1} req_e;
   localparam int IMEM_DEPTH = 32;
   localparam int IMEM_AW = 5;
   localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/imem_rr_arb2.sv
// imem_rr_arb2: two-requester round-robin arbiter (loader vs fetch), active only when enabled
module imem_rr_arb2
   import imem_load_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic req_ld_i,
   input  logic req_f_i,
   output logic gnt_ld_o,
   output logic gnt_f_o
);
   req_e fav_q, fav_d;
   logic contested;
   assign contested = en_i & req_ld_i & req_f_i;
   assign gnt_ld_o = en_i & req_ld_i & (!req_f_i | fav_q == LOADER);
   assign gnt_f_o = en_i & req_f_i & (!req_ld_i | fav_q == FETCH);
   // Favour flips only when both requesters collide; the first collision after reset goes to the loader
   always_comb fav_d = contested ? ((fav_q == LOADER) ? FETCH : LOADER) : fav_q;
   // Favoured-requester register
   always_ff @(posedge clk or negedge rst)
      if (!rst) fav_q <= LOADER;
      else fav_q <= fav_d;
endmodule

// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: boot-loads the 32-word IMEM then shares it between fetch and loader patches; optional checksum via IMEM_LOAD_CHKSUM_EN
module imem_load_arbiter
   import imem_load_arbiter_pkg::*;
#(
   parameter int DEPTH = IMEM_DEPTH,
   parameter int AW = IMEM_AW,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fetch_req,
   input  logic [31:0]   fetch_addr,
   output logic          fetch_gnt,
   output logic          fetch_rvalid,
   output logic [DW-1:0] fetch_rdata,
   output logic          fetch_err,
   output logic          cpu_stall,
   input  logic          ld_valid,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          ld_last,
   output logic          ld_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] ld_chksum
);
   state_e        state_q;
   logic [AW-1:0] ptr_q;
   logic          stall_q, rvalid_q, err_q, err_d, run, gnt_ld, gnt_f, boot_acc;
   logic [DW-1:0] rdata_q, rdata_d;
   assign run = state_q == RUN;
   assign boot_acc = !run & ld_valid;
   imem_rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .en_i     (run),
      .req_ld_i (ld_valid),
      .req_f_i  (fetch_req),
      .gnt_ld_o (gnt_ld),
      .gnt_f_o  (gnt_f)
   );
   assign fetch_gnt = gnt_f;
   assign ld_ready = run ? gnt_ld : 1'b1;
   assign mem_we = run ? gnt_ld : ld_valid;
   assign mem_addr = !run ? ptr_q : gnt_ld ? ld_addr : fetch_addr[AW+1:2];
   assign mem_wdata = ld_data;
   assign cpu_stall = stall_q;
   assign fetch_rvalid = rvalid_q;
   assign fetch_rdata = rdata_q;
   assign fetch_err = err_q;
   // Misaligned or out-of-range fetches return zero with the error flag instead of memory data
   always_comb begin
      err_d = |fetch_addr[1:0] | |fetch_addr[31:AW+2];
      rdata_d = gnt_f ? (err_d ? '0 : mem_rdata) : rdata_q;
   end
   // Boot sequencer: fill words in order, leave LOAD on ld_last or the final word; pointer never wraps
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= LOAD;
         ptr_q <= '0;
         stall_q <= 1'b1;
      end else if (boot_acc) begin
         if (ld_last || ptr_q == AW'(DEPTH - 1)) begin
            state_q <= RUN;
            stall_q <= 1'b0;
         end else ptr_q <= ptr_q + AW'(1);
      end
   // Fetch response registers: one-cycle latency, data held on cycles without a grant
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rvalid_q <= 1'b0;
         err_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         rvalid_q <= gnt_f;
         err_q <= gnt_f & err_d;
         rdata_q <= rdata_d;
      end
`ifdef IMEM_LOAD_CHKSUM_EN
   logic [DW-1:0] chksum_q;
   // XOR of every word accepted during boot; patches in RUN leave it untouched
   always_ff @(posedge clk or negedge rst)
      if (!rst) chksum_q <= '0;
      else if (boot_acc) chksum_q <= chksum_q ^ ld_data;
   assign ld_chksum = chksum_q;
`else
   assign ld_chksum = '0;
`endif
endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb_imem_load_arbiter: table, hand-written and randomized checks of imem_load_arbiter against a behavioural model
module tb_imem_load_arbiter;
   logic clk = 1'b0, rst = 1'b0;
   logic fetch_req = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
   logic [31:0] fetch_addr = '0, ld_data = '0;
   logic [4:0] ld_addr = '0;
   logic fetch_gnt, fetch_rvalid, fetch_err, cpu_stall, ld_ready, mem_we;
   logic [31:0] fetch_rdata, mem_wdata, mem_rdata, ld_chksum;
   logic [4:0] mem_addr;
   logic [31:0] mem [32];
   logic [31:0] img [32];
   logic [31:0] hold_rdata, chk_x;
   logic fav, last_ready;
   int nvec = 0, nerr = 0;
   typedef struct {logic [31:0] addr; logic err; logic [31:0] data;} fvec_t;
   fvec_t tbl [5];
   always #5 clk = ~clk;
   imem_load_arbiter dut (
      .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err), .cpu_stall(cpu_stall),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ld_chksum(ld_chksum)
   );
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask
   function automatic logic [31:0] exp_chksum();
`ifdef IMEM_LOAD_CHKSUM_EN
      return chk_x;
`else
      return 32'h0;
`endif
   endfunction
   task automatic do_reset();
      rst = 1'b0;
      {fetch_req, ld_valid, ld_last} = '0;
      fav = 1'b0;
      chk_x = '0;
      hold_rdata = '0;
      #12;
      @(negedge clk);
      rst = 1'b1;
   endtask
   task automatic boot_word(input logic [31:0] d, input logic last, input int idx);
      @(negedge clk);
      ld_valid = 1'b1; ld_data = d; ld_last = last; ld_addr = 5'(idx + 7);
      #1;
      chk("boot_addr", 32'(mem_addr), 32'(idx));
      chk("boot_we", 32'(mem_we), 32'd1);
      chk("boot_stall", 32'(cpu_stall), 32'd1);
      img[idx] = d;
      chk_x ^= d;
      @(posedge clk);
      #1;
      ld_valid = 1'b0; ld_last = 1'b0;
   endtask
   // One RUN-state cycle checked against the model: rotating priority on collisions, image array, error rule
   task automatic run_cycle(input logic fr, input logic [31:0] fa, input logic lv, input logic [4:0] la, input logic [31:0] ld);
      logic eg_f, eg_l, bad;
      logic [31:0] ed;
      @(negedge clk);
      fetch_req = fr; fetch_addr = fa; ld_valid = lv; ld_addr = la; ld_data = ld; ld_last = 1'b0;
      eg_f = fr && (!lv || fav);
      eg_l = lv && (!fr || !fav);
      if (fr && lv) fav = ~fav;
      bad = (fa % 4 != 0) || (fa >= 32'd128);
      ed = bad ? 32'h0 : img[fa / 4];
      #1;
      chk("fetch_gnt", 32'(fetch_gnt), 32'(eg_f));
      chk("ld_ready", 32'(ld_ready), 32'(eg_l));
      chk("mem_we", 32'(mem_we), 32'(eg_l));
      if (eg_l) chk("patch_addr", 32'(mem_addr), 32'(la));
      last_ready = ld_ready;
      if (eg_l) img[la] = ld;
      @(posedge clk);
      #1;
      chk("rvalid", 32'(fetch_rvalid), 32'(eg_f));
      if (eg_f) begin
         chk("ferr", 32'(fetch_err), 32'(bad));
         hold_rdata = ed;
      end
      chk("rdata", fetch_rdata, hold_rdata);
      fetch_req = 1'b0; ld_valid = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 32; i++) begin mem[i] = '0; img[i] = '0; end
      tbl[0] = '{32'h0000_0004, 1'b0, 32'h4134_8A33};
      tbl[1] = '{32'h0000_0000, 1'b0, 32'h0139_04B3};
      tbl[2] = '{32'h0000_0006, 1'b1, 32'h0000_0000};
      tbl[3] = '{32'h0000_0080, 1'b1, 32'h0000_0000};
      tbl[4] = '{32'h0000_0008, 1'b0, 32'h0000_0000};
      do_reset();
      fetch_req = 1'b1; fetch_addr = 32'h4;
      #1;
      chk("rst_stall", 32'(cpu_stall), 32'd1);
      chk("rst_rvalid", 32'(fetch_rvalid), 32'd0);
      chk("rst_rdata", fetch_rdata, 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      chk("rst_chksum", ld_chksum, 32'd0);
      chk("load_ready", 32'(ld_ready), 32'd1);
      chk("load_no_gnt", 32'(fetch_gnt), 32'd0);
      fetch_req = 1'b0;
      boot_word(32'h0139_04B3, 1'b0, 0);
      boot_word(32'h4134_8A33, 1'b1, 1);
      chk("boot_run_stall", 32'(cpu_stall), 32'd0);
      chk("boot_mem0", mem[0], 32'h0139_04B3);
      chk("boot_mem1", mem[1], 32'h4134_8A33);
      chk("boot_chksum", ld_chksum, exp_chksum());
      foreach (tbl[i]) begin
         @(negedge clk);
         fetch_req = 1'b1; fetch_addr = tbl[i].addr;
         #1;
         chk("tbl_gnt", 32'(fetch_gnt), 32'd1);
         @(posedge clk);
         #1;
         fetch_req = 1'b0;
         chk("tbl_rvalid", 32'(fetch_rvalid), 32'd1);
         chk("tbl_err", 32'(fetch_err), 32'(tbl[i].err));
         chk("tbl_rdata", fetch_rdata, tbl[i].data);
         hold_rdata = tbl[i].data;
      end
      run_cycle(1'b0, 32'h4, 1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         run_cycle(1'b1, 32'h14, 1'b1, 5'd5, 32'hC0DE_0000 + 32'(i));
         chk("rr_order", 32'(last_ready), 32'(i % 2 == 0));
      end
      chk("run_chksum_frozen", ld_chksum, exp_chksum());
      for (int n = 0; n < 300; n++) begin
         logic [31:0] fa;
         int r;
         fa = 32'($urandom_range(0, 31)) * 4;
         r = $urandom_range(0, 7);
         if (r == 0) fa[1:0] = 2'($urandom_range(1, 3));
         if (r == 1) fa = fa | (32'h80 << $urandom_range(0, 24));
         run_cycle(1'($urandom), fa, 1'($urandom), 5'($urandom), $urandom);
      end
      @(negedge clk);
      fetch_req = 1'b1; fetch_addr = 32'h4;
      @(posedge clk);
      #1;
      fetch_req = 1'b0;
      chk("pre_rst_rvalid", 32'(fetch_rvalid), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("async_rvalid", 32'(fetch_rvalid), 32'd0);
      chk("async_rdata", fetch_rdata, 32'd0);
      chk("async_stall", 32'(cpu_stall), 32'd1);
      do_reset();
      for (int i = 0; i < 32; i++) boot_word($urandom, 1'b0, i);
      chk("full_stall", 32'(cpu_stall), 32'd0);
      chk("full_chksum", ld_chksum, exp_chksum());
      chk("full_mem31", mem[31], img[31]);
      run_cycle(1'b0, 32'h0, 1'b1, 5'd3, 32'hDEAD_BEEF);
      run_cycle(1'b1, 32'hC, 1'b0, 5'd0, 32'h0);
      run_cycle(1'b1, 32'h7C, 1'b0, 5'd0, 32'h0);
      run_cycle(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
      chk("full_chksum_frozen", ld_chksum, exp_chksum());
      do_reset();
      for (int i = 0; i < 3; i++) boot_word(32'h1111_0000 + 32'(i), 1'b0, i);
      #2 rst = 1'b0;
      #1;
      chk("midload_stall", 32'(cpu_stall), 32'd1);
      chk("midload_rvalid", 32'(fetch_rvalid), 32'd0);
      chk("midload_err", 32'(fetch_err), 32'd0);
      chk("midload_chksum", ld_chksum, 32'd0);
      do_reset();
      boot_word(32'h2222_0000, 1'b0, 0);
      boot_word(32'h2222_0001, 1'b1, 1);
      chk("reload_stall", 32'(cpu_stall), 32'd0);
      chk("reload_chksum", ld_chksum, exp_chksum());
      run_cycle(1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
      run_cycle(1'b1, 32'h4, 1'b0, 5'd0, 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
